// File: rtl/block_match_sched_multi_if.sv
// Engine-side bus of the block-match scheduler.
//  master (scheduler): drives one-hot start strobes plus the block/search
//                      addresses and block index that travel with them,
//                      listens to the per-engine idle levels.
//  slave  (engine array): the mirror image.
// NUM_CH and ADDR_W must match the scheduler instance it is bound to.
interface block_match_sched_multi_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 16
);
  logic [NUM_CH-1:0] bm_start;        // one-hot, one cycle per issued block
  logic [NUM_CH-1:0] bm_done;         // engine i idle (level)
  logic [ADDR_W-1:0] blk_addr_left;   // valid with bm_start, held afterwards
  logic [ADDR_W-1:0] blk_addr_right;
  logic [ADDR_W-1:0] srch_addr;       // shared by the left/right pair
  logic [15:0]       blk_index;       // {img_number, row[5:0], col[5:0]}

  modport master (
    output bm_start, blk_addr_left, blk_addr_right, srch_addr, blk_index,
    input  bm_done
  );

  modport slave (
    input  bm_start, blk_addr_left, blk_addr_right, srch_addr, blk_index,
    output bm_done
  );
endinterface

// File: rtl/block_match_sched_multi.sv
// Block-match control scheduler.
// Walks the block grid of one stereo frame and hands blocks to NUM_CH
// left/right engine pairs, lowest idle engine first, at most one issue per
// clock. Frames come from an NUM_BUFS-deep buffer ring; the set of usable
// engines is latched once per frame from ch_enable.
// Ports:
//  clk, reset      clock, asynchronous active-high reset
//  img_number_in   frame counter from the writer; a new value starts a frame
//  ch_enable       engines usable this frame (sampled at frame start)
//  bm              engine bus (master side): start strobes, addresses,
//                  block index out; per-engine idle levels in
//  bm_idle         scheduler idle and every engine idle
//  bm_working_buf  ring slot of the frame being processed
//  frame_done      one-cycle pulse after the last block has been finished
module block_match_sched_multi #(
  parameter int NUM_CH    = 2,
  parameter int NUM_BUFS  = 2,
  parameter int BUF_W     = (NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1,
  parameter int RD_PORT_W = 8,
  parameter int THIRD_W   = 240,
  parameter int CENTER_W  = 304,
  parameter int THIRD_H   = 480,
  parameter int BLK_W     = 16,
  parameter int BLK_H     = 16,
  parameter int SRCH_W    = 64,
  parameter int SRCH_H    = 32,
  parameter int ADDR_W    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [3:0]                img_number_in,
  input  logic [NUM_CH-1:0]         ch_enable,
  block_match_sched_multi_if.master bm,
  output logic                      bm_idle,
  output logic [BUF_W-1:0]          bm_working_buf,
  output logic                      frame_done
);

  // Geometry in memory words.
  localparam int FAW       = THIRD_W / RD_PORT_W;
  localparam int CAW       = CENTER_W / RD_PORT_W;
  localparam int BAW       = BLK_W / RD_PORT_W;
  localparam int COLS      = THIRD_W / BLK_W + ((CENTER_W - THIRD_W) / BLK_W) / 2;
  localparam int ROWS      = (THIRD_H - SRCH_H) / BLK_H;
  localparam int INIT_L    = FAW * ((SRCH_H - BLK_H) / 2);
  localparam int RIGHT_OFF = SRCH_W / RD_PORT_W - BAW;

  localparam logic [ADDR_W-1:0] A_BAW    = ADDR_W'(BAW);
  localparam logic [ADDR_W-1:0] A_SROW   = ADDR_W'(CAW * BLK_H);
  localparam logic [ADDR_W-1:0] A_BROW   = ADDR_W'(FAW * BLK_H);
  localparam logic [ADDR_W-1:0] A_SBUF   = ADDR_W'(CAW * THIRD_H);
  localparam logic [ADDR_W-1:0] A_BBUF   = ADDR_W'(FAW * THIRD_H);
  localparam logic [ADDR_W-1:0] A_INIT_L = ADDR_W'(INIT_L);
  localparam logic [ADDR_W-1:0] A_ROFF   = ADDR_W'(RIGHT_OFF);
  localparam logic [5:0]        LAST_COL = 6'(COLS - 1);
  localparam logic [5:0]        LAST_ROW = 6'(ROWS - 1);
  localparam logic [3:0]        BUF_MASK = 4'(NUM_BUFS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t              state_q, state_d;
  logic [3:0]          img_q, img_d;
  logic [NUM_CH-1:0]   en_q, en_d;
  logic [NUM_CH-1:0]   pend_q, pend_d;
  logic [NUM_CH-1:0]   start_q, start_d;
  logic [5:0]          row_q, row_d, col_q, col_d;
  // Buffer bases and row bases are stepped, never multiplied.
  logic [ADDR_W-1:0]   sb_q, sb_d, bb_q, bb_d;
  logic [ADDR_W-1:0]   srow_q, srow_d, brow_q, brow_d, coff_q, coff_d;
  logic [ADDR_W-1:0]   srch_q, srch_d, bl_q, bl_d, br_q, br_d;
  logic [15:0]         idx_q, idx_d;
  logic                fd_q, fd_d;
  logic [NUM_CH-1:0]   elig, lowest;

  always_comb begin
    elig   = en_q & bm.bm_done & ~pend_q;
    lowest = elig & (~elig + NUM_CH'(1));   // isolate lowest set bit

    state_d = state_q;
    img_d   = img_q;
    en_d    = en_q;
    start_d = '0;
    row_d   = row_q;
    col_d   = col_q;
    sb_d    = sb_q;
    bb_d    = bb_q;
    srow_d  = srow_q;
    brow_d  = brow_q;
    coff_d  = coff_q;
    srch_d  = srch_q;
    bl_d    = bl_q;
    br_d    = br_q;
    idx_d   = idx_q;
    fd_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (img_number_in != img_q && (&bm.bm_done) && (|ch_enable)) begin
          en_d    = ch_enable;
          row_d   = '0;
          col_d   = '0;
          coff_d  = '0;
          srow_d  = sb_q;
          brow_d  = bb_q + A_INIT_L;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (|elig) begin
          start_d = lowest;
          srch_d  = srow_q + coff_q;
          bl_d    = brow_q + coff_q;
          br_d    = brow_q + coff_q - A_ROFF;
          idx_d   = {img_q, row_q, col_q};
          if (col_q == LAST_COL) begin
            col_d  = '0;
            coff_d = '0;
            row_d  = row_q + 6'd1;
            srow_d = srow_q + A_SROW;
            brow_d = brow_q + A_BROW;
            if (row_q == LAST_ROW) state_d = S_DRAIN;
          end else begin
            col_d  = col_q + 6'd1;
            coff_d = coff_q + A_BAW;
          end
        end
      end
      S_DRAIN: begin
        if (pend_q == '0 && (&(bm.bm_done | ~en_q))) begin
          fd_d    = 1'b1;
          img_d   = img_q + 4'd1;
          state_d = S_IDLE;
          // The ring slot follows img_number; a 4-bit wrap also lands on slot 0.
          if (((img_q + 4'd1) & BUF_MASK) == 4'd0) begin
            sb_d = '0;
            bb_d = '0;
          end else begin
            sb_d = sb_q + A_SBUF;
            bb_d = bb_q + A_BBUF;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Pending spans from the start strobe until the engine is first seen busy.
    pend_d = start_d | (pend_q & bm.bm_done);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      img_q   <= '0;
      en_q    <= '0;
      pend_q  <= '0;
      start_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
      sb_q    <= '0;
      bb_q    <= '0;
      srow_q  <= '0;
      brow_q  <= '0;
      coff_q  <= '0;
      srch_q  <= '0;
      bl_q    <= '0;
      br_q    <= '0;
      idx_q   <= '0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      img_q   <= img_d;
      en_q    <= en_d;
      pend_q  <= pend_d;
      start_q <= start_d;
      row_q   <= row_d;
      col_q   <= col_d;
      sb_q    <= sb_d;
      bb_q    <= bb_d;
      srow_q  <= srow_d;
      brow_q  <= brow_d;
      coff_q  <= coff_d;
      srch_q  <= srch_d;
      bl_q    <= bl_d;
      br_q    <= br_d;
      idx_q   <= idx_d;
      fd_q    <= fd_d;
    end
  end

  assign bm.bm_start       = start_q;
  assign bm.srch_addr      = srch_q;
  assign bm.blk_addr_left  = bl_q;
  assign bm.blk_addr_right = br_q;
  assign bm.blk_index      = idx_q;
  assign bm_idle           = (state_q == S_IDLE) && (&bm.bm_done);
  assign bm_working_buf    = BUF_W'(img_q & BUF_MASK);
  assign frame_done        = fd_q;

endmodule

// File: tb/tb_block_match_sched_multi.sv
// Bench for block_match_sched_multi: reactive engine models, a frame-level
// reference model checked every cycle, and literal spot checks.
module tb_block_match_sched_multi;
  localparam int NUM_CH = 2, NUM_BUFS = 2, ADDR_W = 16, BUF_W = 1;
  // Hand-derived geometry for the default image sizes.
  localparam int FAW = 30, CAW = 38, BAW = 2, COLS = 17, ROWS = 28;
  localparam int INIT_L = 240, RIGHT_OFF = 6, IMG_H = 480, BLK_H = 16;
  localparam int NBLK = COLS * ROWS;

  logic              clk, reset;
  logic [3:0]        img_in;
  logic [NUM_CH-1:0] ch_en;
  logic              bm_idle, frame_done;
  logic [BUF_W-1:0]  wbuf;

  block_match_sched_multi_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) bm_if ();

  block_match_sched_multi #(.NUM_CH(NUM_CH), .NUM_BUFS(NUM_BUFS), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .img_number_in  (img_in),
    .ch_enable      (ch_en),
    .bm             (bm_if),
    .bm_idle        (bm_idle),
    .bm_working_buf (wbuf),
    .frame_done     (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec, n_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          ph, k;   // ph: 0 idle, 1 issuing, 2 draining
  logic [3:0]  img_m;
  logic [1:0]  en_m, pend_m, elig_m, ns;
  logic        nfd;
  logic [1:0]  e_start;
  logic [15:0] e_srch, e_bl, e_br, e_idx;
  logic        e_fd;

  // Observation bookkeeping for the literal checks.
  int          cyc, n_sf, fd_cnt;
  int          n_eng [NUM_CH];
  int          r_srch [18], r_bl [18], r_br [18];
  logic [15:0] r_idx [18];
  logic        r_buf [18];
  int          r_eng [2], r_cyc [2];
  logic [15:0] fq [$];

  // Addresses of block kk of frame img straight from the grid formulas.
  task automatic model_block(input int kk, input logic [3:0] img,
                             output logic [15:0] s, output logic [15:0] bl,
                             output logic [15:0] br, output logic [15:0] idx);
    int b, row, col;
    b   = int'(img) % NUM_BUFS;
    row = kk / COLS;
    col = kk % COLS;
    s   = 16'(b * CAW * IMG_H + row * CAW * BLK_H + col * BAW);
    bl  = 16'(b * FAW * IMG_H + INIT_L + row * FAW * BLK_H + col * BAW);
    br  = 16'(b * FAW * IMG_H + INIT_L + row * FAW * BLK_H + col * BAW - RIGHT_OFF);
    idx = {img, 6'(row), 6'(col)};
  endtask

  task monitor();
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        chk("rst_bm_start", bm_if.bm_start, 0);
        chk("rst_srch", bm_if.srch_addr, 0);
        chk("rst_blk_l", bm_if.blk_addr_left, 0);
        chk("rst_blk_r", bm_if.blk_addr_right, 0);
        chk("rst_blk_index", bm_if.blk_index, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_wbuf", wbuf, 0);
        chk("rst_bm_idle", bm_idle, &bm_if.bm_done);
        ph = 0; k = 0; img_m = '0; en_m = '0; pend_m = '0;
        e_start = '0; e_srch = '0; e_bl = '0; e_br = '0; e_idx = '0; e_fd = 1'b0;
      end else begin
        chk("bm_start", bm_if.bm_start, e_start);
        chk("srch_addr", bm_if.srch_addr, e_srch);
        chk("blk_addr_left", bm_if.blk_addr_left, e_bl);
        chk("blk_addr_right", bm_if.blk_addr_right, e_br);
        chk("blk_index", bm_if.blk_index, e_idx);
        chk("frame_done", frame_done, e_fd);
        chk("bm_idle", bm_idle, (ph == 0) && (&bm_if.bm_done));
        chk("working_buf", wbuf, int'(img_m) % NUM_BUFS);

        if (bm_if.bm_start != '0) begin
          if (n_sf < 18) begin
            r_srch[n_sf] = int'(bm_if.srch_addr);
            r_bl[n_sf]   = int'(bm_if.blk_addr_left);
            r_br[n_sf]   = int'(bm_if.blk_addr_right);
            r_idx[n_sf]  = bm_if.blk_index;
            r_buf[n_sf]  = wbuf;
          end
          if (n_sf < 2) begin
            r_eng[n_sf] = int'(bm_if.bm_start);
            r_cyc[n_sf] = cyc;
          end
          for (int i = 0; i < NUM_CH; i++) if (bm_if.bm_start[i]) n_eng[i]++;
          if (bm_if.blk_index[11:0] == 12'd0) fq.push_back(bm_if.blk_index);
          n_sf++;
        end
        if (frame_done) fd_cnt++;

        // Advance the model by one clock using this cycle's inputs.
        elig_m = en_m & bm_if.bm_done & ~pend_m;
        ns  = '0;
        nfd = 1'b0;
        case (ph)
          0: if (img_in != img_m && (&bm_if.bm_done) && (|ch_en)) begin
               en_m = ch_en; k = 0; ph = 1;
             end
          1: begin
               for (int i = 0; i < NUM_CH; i++) if (elig_m[i] && ns == '0) ns[i] = 1'b1;
               if (ns != '0) begin
                 model_block(k, img_m, e_srch, e_bl, e_br, e_idx);
                 k++;
                 if (k == NBLK) ph = 2;
               end
             end
          default: if (pend_m == '0 && (&(bm_if.bm_done | ~en_m))) begin
               nfd = 1'b1; img_m = img_m + 4'd1; ph = 0;
             end
        endcase
        pend_m  = (pend_m & bm_if.bm_done) | ns;
        e_start = ns;
        e_fd    = nfd;
      end
    end
  endtask

  // ---------------- engine models ----------------
  // tmode 0: ack after 1, idle again after 10; 1: random; 2: random, engine 0 slow.
  int cnt [NUM_CH], aend [NUM_CH], wend [NUM_CH];
  int tmode;

  task engines();
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (cnt[i] >= 0) begin
          cnt[i]++;
          if (cnt[i] >= wend[i]) cnt[i] = -1;
        end
        if (bm_if.bm_start[i]) begin
          cnt[i] = 0;
          if (tmode == 0) begin
            aend[i] = 1; wend[i] = 10;
          end else begin
            aend[i] = int'($urandom_range(1, 3));
            wend[i] = aend[i] + int'($urandom_range(1, 8)) + ((tmode == 2 && i == 0) ? 25 : 0);
          end
        end
        bm_if.bm_done[i] = !(cnt[i] >= 0 && cnt[i] >= aend[i]);
      end
    end
  endtask

  task automatic wait_fd(input int target, input int budget);
    int c = 0;
    while (fd_cnt < target && c < budget) begin @(posedge clk); c++; end
    chk("frame_done_reached", fd_cnt >= target, 1);
  endtask

  task automatic wait_starts(input int target, input int budget);
    int c = 0;
    while (n_sf < target && c < budget) begin @(posedge clk); c++; end
    chk("starts_reached", n_sf >= target, 1);
  endtask

  int f0;

  initial begin
    reset = 1'b1; img_in = 4'd0; ch_en = 2'b11; bm_if.bm_done = '1; tmode = 0;
    n_vec = 0; n_err = 0; cyc = 0; n_sf = 0; fd_cnt = 0;
    for (int i = 0; i < NUM_CH; i++) begin cnt[i] = -1; aend[i] = 1; wend[i] = 1; n_eng[i] = 0; end
    ph = 0; k = 0; img_m = '0; en_m = '0; pend_m = '0;
    e_start = '0; e_srch = '0; e_bl = '0; e_br = '0; e_idx = '0; e_fd = 1'b0;
    fork
      monitor();
      engines();
    join_none

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk); #1;
    chk("init_bm_start", bm_if.bm_start, 0);
    chk("init_srch", bm_if.srch_addr, 0);
    chk("init_blk_index", bm_if.blk_index, 0);
    chk("init_bm_idle", bm_idle, 1);
    chk("init_wbuf", wbuf, 0);

    // Frame 0, deterministic engine timing.
    @(posedge clk); #1;
    n_sf = 0; f0 = fd_cnt; img_in = 4'd1;
    wait_fd(f0 + 1, 20000);
    repeat (20) @(posedge clk);
    chk("f0_starts", n_sf, 476);
    chk("f0_frame_done_once", fd_cnt, f0 + 1);
    chk("f0_b0_srch", r_srch[0], 0);
    chk("f0_b0_blk_l", r_bl[0], 240);
    chk("f0_b0_blk_r", r_br[0], 234);
    chk("f0_b1_srch", r_srch[1], 2);
    chk("f0_b1_blk_l", r_bl[1], 242);
    chk("f0_b17_srch", r_srch[17], 608);
    chk("f0_b17_blk_l", r_bl[17], 720);
    chk("f0_b17_index", r_idx[17], 32'h0040);

    // Frame 1, random engine timing, second ring slot.
    @(posedge clk); #1;
    tmode = 1; n_sf = 0; f0 = fd_cnt; img_in = 4'd2;
    wait_fd(f0 + 1, 20000);
    chk("f1_starts", n_sf, 476);
    chk("f1_b0_srch", r_srch[0], 18240);
    chk("f1_b0_blk_l", r_bl[0], 14640);
    chk("f1_b0_blk_r", r_br[0], 14634);
    chk("f1_b0_index", r_idx[0], 32'h1000);
    chk("f1_b0_wbuf", r_buf[0], 1);
    chk("f1_first_engine", r_eng[0], 1);
    chk("f1_second_engine", r_eng[1], 2);
    chk("f1_back_to_back", r_cyc[1] - r_cyc[0], 1);

    // Frame 2 on engine 1 only.
    @(posedge clk); #1;
    for (int i = 0; i < NUM_CH; i++) n_eng[i] = 0;
    n_sf = 0; f0 = fd_cnt; ch_en = 2'b10; img_in = 4'd3;
    wait_fd(f0 + 1, 30000);
    chk("f2_eng0_starts", n_eng[0], 0);
    chk("f2_eng1_starts", n_eng[1], 476);

    // No engines enabled: must stay idle.
    @(posedge clk); #1;
    n_sf = 0; f0 = fd_cnt; ch_en = 2'b00; img_in = 4'd4;
    repeat (50) @(posedge clk);
    chk("noen_starts", n_sf, 0);
    chk("noen_idle", bm_idle, 1);
    chk("noen_wbuf", wbuf, 1);

    // Re-enable with a slow engine 0.
    #1 tmode = 2; ch_en = 2'b11;
    wait_fd(f0 + 1, 30000);
    chk("f3_starts", n_sf, 476);

    // Reset, then a mid-frame img_number_in jump.
    @(posedge clk); #1;
    reset = 1'b1; img_in = 4'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    fq.delete();
    n_sf = 0; f0 = fd_cnt; tmode = 1; ch_en = 2'b11; img_in = 4'd1;
    wait_starts(100, 5000);
    @(posedge clk); #1 img_in = 4'd3;
    wait_fd(f0 + 3, 40000);
    repeat (40) @(posedge clk);
    chk("jump_frames", fd_cnt, f0 + 3);
    chk("jump_nframes", fq.size(), 3);
    if (fq.size() == 3) begin
      chk("jump_frame0", fq[0], 32'h0000);
      chk("jump_frame1", fq[1], 32'h1000);
      chk("jump_frame2", fq[2], 32'h2000);
    end
    chk("jump_wbuf", wbuf, 1);

    // Reset in the middle of frame 3.
    @(posedge clk); #1;
    n_sf = 0; img_in = 4'd0;
    wait_starts(100, 5000);
    @(posedge clk); #2 reset = 1'b1;
    @(negedge clk); #1;
    chk("midrst_bm_start", bm_if.bm_start, 0);
    chk("midrst_srch", bm_if.srch_addr, 0);
    chk("midrst_blk_l", bm_if.blk_addr_left, 0);
    chk("midrst_index", bm_if.blk_index, 0);
    chk("midrst_frame_done", frame_done, 0);
    chk("midrst_wbuf", wbuf, 0);
    @(posedge clk); #1;
    reset = 1'b0; n_sf = 0; f0 = fd_cnt; img_in = 4'd1;
    wait_fd(f0 + 1, 20000);
    chk("restart_starts", n_sf, 476);
    chk("restart_b0_srch", r_srch[0], 0);
    chk("restart_b0_blk_l", r_bl[0], 240);
    chk("restart_b0_index", r_idx[0], 0);

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
